// File: rtl/add_pipe.sv
// add_pipe: carry-pipelined adder/subtractor with a valid/ready handshake.
//
// The WIDTH-bit operation is cut into N = WIDTH/GROUP slices. Stage k adds
// slice k of A and the effective B together with the carry registered by
// stage k-1. Operand slices that have not been consumed yet travel alongside
// in a shrinking skew register. Finished sum slices accumulate in a growing
// deskew register. As a result, all WIDTH result bits of one operation reach
// the last stage in the same cycle.
//
// A single global advance signal moves every stage at once. When the output
// is stalled, the whole pipe freezes. Empty slots travel as valid=0 entries
// and are never squeezed out, so the latency is always N cycles when the
// output is never stalled.
module add_pipe #(
    parameter int WIDTH = 32,
    parameter int GROUP = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_1,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int N = WIDTH / GROUP;

    logic             adv;
    logic [WIDTH-1:0] bEff;
    logic             cinEff;

    // Subtraction is a + ~b + 1. The inversion and the forced carry-in are
    // applied before the first register, so they are captured together with
    // the operands at acceptance.
    assign bEff   = sub ? ~b : b;
    assign cinEff = sub ? 1'b1 : c_1;

    for (genvar k = 0; k < N; k++) begin : gStage

        // InW:  operand bits still unconsumed when they enter stage k.
        // SumW: result bits known after stage k has added its slice.
        localparam int InW  = WIDTH - k * GROUP;
        localparam int SumW = (k + 1) * GROUP;

        logic             validIn;
        logic             carryIn;
        logic [InW-1:0]   opAIn;
        logic [InW-1:0]   opBIn;
        logic [GROUP:0]   grpSum;
        logic [SumW-1:0]  sum_d;

        logic             valid_q;
        logic             carry_q;
        logic [SumW-1:0]  sum_q;

        if (k == 0) begin : gHead
            // The first stage reads the live operand bus directly.
            assign validIn = in_valid;
            assign carryIn = cinEff;
            assign opAIn   = a;
            assign opBIn   = bEff;
            assign sum_d   = grpSum[GROUP-1:0];
        end else begin : gBody
            // Later stages read the registers of the previous stage.
            // The new slice is placed above the sum bits already finished.
            assign validIn = gStage[k-1].valid_q;
            assign carryIn = gStage[k-1].carry_q;
            assign opAIn   = gStage[k-1].gSkew.opA_q;
            assign opBIn   = gStage[k-1].gSkew.opB_q;
            assign sum_d   = {grpSum[GROUP-1:0], gStage[k-1].sum_q};
        end

        // Add the lowest unconsumed slice. The extra top bit is the carry
        // handed to the next stage.
        assign grpSum = {1'b0, opAIn[GROUP-1:0]}
                      + {1'b0, opBIn[GROUP-1:0]}
                      + {{GROUP{1'b0}}, carryIn};

        // Stage valid, carry and deskewed sum move only when the pipe advances.
        // Reset empties the stage, which discards any operation in flight.
        always_ff @(posedge clk) begin
            if (rst) begin
                valid_q <= 1'b0;
                carry_q <= 1'b0;
                sum_q   <= '0;
            end else if (adv) begin
                valid_q <= validIn;
                carry_q <= grpSum[GROUP];
                sum_q   <= sum_d;
            end
        end

        if (k < N - 1) begin : gSkew
            localparam int OutW = InW - GROUP;

            logic [OutW-1:0] opA_q;
            logic [OutW-1:0] opB_q;

            // Forward the still-unused upper operand slices to the next stage.
            always_ff @(posedge clk) begin
                if (rst) begin
                    opA_q <= '0;
                    opB_q <= '0;
                end else if (adv) begin
                    opA_q <= opAIn[InW-1:GROUP];
                    opB_q <= opBIn[InW-1:GROUP];
                end
            end
        end else begin : gTail
            logic ovf_q;

            // The top slice carries the sign bits of A and the effective B, so
            // signed overflow is resolved here, in the same cycle as the sum MSB.
            always_ff @(posedge clk) begin
                if (rst) begin
                    ovf_q <= 1'b0;
                end else if (adv) begin
                    ovf_q <= (opAIn[GROUP-1] == opBIn[GROUP-1])
                           & (grpSum[GROUP-1] != opAIn[GROUP-1]);
                end
            end
        end
    end

    // The last stage holds the complete, aligned result.
    assign out_valid = gStage[N-1].valid_q;
    assign s         = gStage[N-1].sum_q;
    assign cout      = gStage[N-1].carry_q;
    assign ovf       = gStage[N-1].gTail.ovf_q;

    // zero is taken from the delivered s itself, so it can never disagree with
    // s. It is gated by out_valid, so it reads 0 while the output is empty.
    assign zero = out_valid & ~|s;

    // The pipe moves whenever the output slot is empty or is being consumed.
    assign adv      = ~out_valid | out_ready;
    assign in_ready = adv;

endmodule

// File: tb/tb_add_pipe.sv
// tb_add_pipe: self-checking bench for add_pipe (WIDTH=32, GROUP=8).
//
// The reference model is a transaction-level picture of the pipe: N result
// slots that shift together whenever the output is free or is being taken.
// Each slot holds an expected result computed with plain 33-bit arithmetic.
// Every cycle, the DUT handshake and output fields are compared against the
// slot at the output end.
module tb_add_pipe;

    localparam int WIDTH = 32;
    localparam int GROUP = 8;
    localparam int N     = WIDTH / GROUP;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             c_1;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] s;
    logic             cout;
    logic             ovf;
    logic             zero;

    add_pipe #(
        .WIDTH(WIDTH),
        .GROUP(GROUP)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .c_1       (c_1),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .s         (s),
        .cout      (cout),
        .ovf       (ovf),
        .zero      (zero)
    );

    // Free-running clock, 10 time units per cycle.
    always #5 clk = ~clk;

    typedef struct {
        logic        valid;
        logic [31:0] s;
        logic        cout;
        logic        ovf;
        logic        zero;
    } slot_t;

    slot_t pipe [N];

    int testsRun       = 0;
    int testsFailed    = 0;
    int acceptedCount  = 0;
    int discardedCount = 0;
    int dutDelivered   = 0;
    bit checksOn       = 1'b0;
    bit lastAccepted   = 1'b0;

    int issued;
    int stallLeft;
    bit seenValid;

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        testsRun++;
        if (observed !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Golden result of one operation, taken straight from the arithmetic rules.
    function automatic slot_t refAdd(input logic [31:0] opA, input logic [31:0] opB,
                                     input logic cin, input logic subMode);
        slot_t       r;
        logic [31:0] beff;
        logic [32:0] full;
        beff   = subMode ? ~opB : opB;
        full   = {1'b0, opA} + {1'b0, beff} + {32'd0, (subMode ? 1'b1 : cin)};
        r.valid = 1'b1;
        r.s     = full[31:0];
        r.cout  = full[32];
        r.ovf   = (opA[31] == beff[31]) && (r.s[31] != opA[31]);
        r.zero  = (r.s == 32'd0);
        return r;
    endfunction

    function automatic logic [31:0] pickOperand();
        logic [31:0] v;
        case ($urandom_range(0, 7))
            0:       v = 32'h0000_0000;
            1:       v = 32'hFFFF_FFFF;
            2:       v = 32'h7FFF_FFFF;
            3:       v = 32'h8000_0000;
            default: v = $urandom;
        endcase
        return v;
    endfunction

    // Drive one cycle of inputs, check the outputs against the model,
    // then advance the model and the clock by one cycle.
    task automatic applyStimulus(input logic v, input logic [31:0] av, input logic [31:0] bv,
                                 input logic cv, input logic sv, input logic rdy,
                                 input logic rv);
        slot_t head;
        slot_t idle;
        logic  modelAdv;
        in_valid  = v;
        a         = av;
        b         = bv;
        c_1       = cv;
        sub       = sv;
        out_ready = rdy;
        rst       = rv;
        #1;
        idle         = '{default: '0};
        head         = pipe[N-1];
        modelAdv     = !head.valid || rdy;
        lastAccepted = v && modelAdv && !rv;
        if (checksOn) begin
            checkOutput("out_valid", out_valid, head.valid);
            checkOutput("in_ready", in_ready, modelAdv);
            checkOutput("zero", zero, head.valid ? head.zero : 1'b0);
            if (head.valid) begin
                checkOutput("s", s, head.s);
                checkOutput("cout", cout, head.cout);
                checkOutput("ovf", ovf, head.ovf);
            end
        end
        if (out_valid === 1'b1 && rdy && !rv) dutDelivered++;
        if (rv) begin
            for (int i = 0; i < N; i++) begin
                if (pipe[i].valid) discardedCount++;
                pipe[i] = idle;
            end
        end else if (modelAdv) begin
            for (int i = N - 1; i > 0; i--) pipe[i] = pipe[i-1];
            pipe[0] = lastAccepted ? refAdd(av, bv, cv, sv) : idle;
        end
        if (lastAccepted) acceptedCount++;
        @(posedge clk);
        @(negedge clk);
    endtask

    // Issue a single operation into an empty pipe, measure its latency and
    // compare the result against hand-derived constants.
    task automatic runSingle(input string tag, input logic [31:0] av, input logic [31:0] bv,
                             input logic cv, input logic sv, input logic [31:0] expS,
                             input logic expCout, input logic expOvf, input logic expZero);
        int lat;
        applyStimulus(1'b1, av, bv, cv, sv, 1'b1, 1'b0);
        lat = 1;
        while (out_valid !== 1'b1 && lat < 20) begin
            applyStimulus(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0);
            lat++;
        end
        checkOutput({tag, "_latency"}, lat, N);
        checkOutput({tag, "_s"}, s, expS);
        checkOutput({tag, "_cout"}, cout, expCout);
        checkOutput({tag, "_ovf"}, ovf, expOvf);
        checkOutput({tag, "_zero"}, zero, expZero);
        applyStimulus(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    // Top-level test sequence.
    initial begin
        for (int i = 0; i < N; i++) pipe[i] = '{default: '0};

        // Reset. During the second reset cycle an operation is offered;
        // it must not be accepted.
        applyStimulus(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b1);
        checksOn = 1'b1;
        applyStimulus(1'b1, 32'h1234_5678, 32'h0000_0001, 1'b0, 1'b0, 1'b1, 1'b1);
        checkOutput("reset_out_valid", out_valid, 1'b0);
        checkOutput("reset_s", s, 32'd0);
        checkOutput("reset_cout", cout, 1'b0);
        checkOutput("reset_ovf", ovf, 1'b0);
        checkOutput("reset_zero", zero, 1'b0);
        checkOutput("reset_in_ready", in_ready, 1'b1);

        // Directed arithmetic corner cases.
        runSingle("ripple", 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0,
                  32'h0000_0000, 1'b1, 1'b0, 1'b1);
        runSingle("sub_5_7", 32'd5, 32'd7, 1'b0, 1'b1,
                  32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
        runSingle("sub_7_5", 32'd7, 32'd5, 1'b1, 1'b1,
                  32'h0000_0002, 1'b1, 1'b0, 1'b0);
        runSingle("add_ovf", 32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0,
                  32'h8000_0000, 1'b0, 1'b1, 1'b0);
        runSingle("sub_ovf", 32'h8000_0000, 32'd1, 1'b0, 1'b1,
                  32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);
        runSingle("sub_eq", 32'd5, 32'd5, 1'b0, 1'b1,
                  32'h0000_0000, 1'b1, 1'b0, 1'b1);

        // Six back-to-back operations. The output is stalled for three
        // cycles as soon as the first result appears.
        issued    = 0;
        stallLeft = 0;
        seenValid = 1'b0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            logic        rdy;
            logic [31:0] opv;
            if (out_valid === 1'b1 && !seenValid) begin
                seenValid = 1'b1;
                stallLeft = 3;
            end
            rdy = (stallLeft == 0);
            if (stallLeft > 0) stallLeft--;
            opv = 32'(issued + 1);
            applyStimulus(issued < 6, opv, opv << 24, 1'b0, 1'b0, rdy, 1'b0);
            if (lastAccepted) issued++;
        end

        // Three operations in flight when reset arrives; none may ever surface.
        for (int i = 0; i < 3; i++)
            applyStimulus(1'b1, $urandom, $urandom, 1'b0, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b1);
        checkOutput("flush_out_valid", out_valid, 1'b0);
        checkOutput("flush_s", s, 32'd0);
        for (int i = 0; i < 6; i++)
            applyStimulus(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        runSingle("post_reset", 32'h0000_0100, 32'h0000_00FF, 1'b1, 1'b0,
                  32'h0000_0200, 1'b0, 1'b0, 1'b0);

        // Random traffic with random valid/ready patterns.
        for (int cyc = 0; cyc < 600; cyc++) begin
            applyStimulus($urandom_range(0, 9) < 7, pickOperand(), pickOperand(),
                          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          $urandom_range(0, 9) < 7, 1'b0);
        end
        for (int i = 0; i < 12; i++)
            applyStimulus(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0);

        // Every accepted, non-flushed operation was delivered exactly once.
        checkOutput("delivered_count", dutDelivered, acceptedCount - discardedCount);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
